// File: rtl/spike_event_scheduler.sv
// Purpose: in-order FIFO of timestamped address events; pulses input_spike[addr] when sys_time reaches the event time, late events dropped and counted.
// Latency: 2 cycles from the head becoming due to its pulse; equal-time events pulse on consecutive cycles.
// Backpressure: ev_ready drops only while the registered fifo_level equals FIFO_DEPTH.
// Option: define SPIKE_SCHED_LATE_FIRE_EN to fire late events immediately (still counted) instead of dropping them.
module spike_event_scheduler #(
    parameter int NUM_SYN    = 8,
    parameter int ADDR_W     = 3,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick,
    input  logic                        ev_valid,
    output logic                        ev_ready,
    input  logic [ADDR_W-1:0]           ev_addr,
    input  logic [TS_W-1:0]             ev_time,
    output logic [TS_W-1:0]             sys_time,
    output logic [NUM_SYN-1:0]          input_spike,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                  late_count
);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
`ifdef SPIKE_SCHED_LATE_FIRE_EN
    localparam bit LATE_FIRE = 1'b1;
`else
    localparam bit LATE_FIRE = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TS_W-1:0]   ts;
    } ev_t;

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_WAIT    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    ev_t                mem_q [FIFO_DEPTH];
    ev_t                mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   level_q, level_d, nxt_ptr;
    logic [TS_W-1:0]    sys_time_q, sys_time_d;
    logic [NUM_SYN-1:0] spike_q, spike_d, head_onehot;
    logic [7:0]         late_cnt_q, late_cnt_d;
    logic               rel_late_q, rel_late_d;

    ev_t                head;
    logic [TS_W-1:0]    nxt_ts, head_diff, nxt_diff;
    logic               head_due, head_late, nxt_due, nxt_late, nxt_same;
    logic               has_next, chain;
    logic               push, pop, fire, late_inc;

    assign ev_ready    = (level_q != PTR_W'(FIFO_DEPTH));
    assign push        = ev_valid && ev_ready;
    assign sys_time    = sys_time_q;
    assign input_spike = spike_q;
    assign fifo_level  = level_q;
    assign late_count  = late_cnt_q;

    // Classify the head and the entry behind it against the pre-tick network time.
    always_comb begin
        nxt_ptr     = rd_ptr_q + PTR_W'(1);
        head        = mem_q[rd_ptr_q[IDX_W-1:0]];
        nxt_ts      = mem_q[nxt_ptr[IDX_W-1:0]].ts;
        head_diff   = head.ts - sys_time_q;
        nxt_diff    = nxt_ts - sys_time_q;
        head_due    = (head_diff == '0);
        head_late   = head_diff[TS_W-1];
        nxt_due     = (nxt_diff == '0);
        nxt_late    = nxt_diff[TS_W-1];
        // An entry sharing the head's time inherits its verdict, so a burst
        // keeps firing even if a tick lands in the middle of it.
        nxt_same    = (nxt_ts == head.ts);
        has_next    = (level_q >= PTR_W'(2));
        chain       = has_next && (nxt_same || nxt_due || nxt_late);
        head_onehot = '0;
        for (int i = 0; i < NUM_SYN; i++) begin
            if (head.addr == ADDR_W'(i)) head_onehot[i] = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_EMPTY;
        else        state_q <= state_d;
    end

    // FSM next state: stay in RELEASE while the following entry is also ready to go.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY:   if (push) state_d = S_WAIT;
            S_WAIT:    if (head_due || head_late) state_d = S_RELEASE;
            S_RELEASE: begin
                if (chain)                                 state_d = S_RELEASE;
                else if (level_q == PTR_W'(1) && !push)    state_d = S_EMPTY;
                else                                       state_d = S_WAIT;
            end
            default:   state_d = S_EMPTY;
        endcase
    end

    // FSM outputs: pop in RELEASE, decide pulse or late drop from the latched verdict.
    always_comb begin
        pop        = 1'b0;
        fire       = 1'b0;
        late_inc   = 1'b0;
        rel_late_d = rel_late_q;
        case (state_q)
            S_WAIT:    rel_late_d = head_late;
            S_RELEASE: begin
                pop        = 1'b1;
                // Out-of-range addresses have an empty one-hot: no pulse, not counted.
                fire       = (|head_onehot) && (!rel_late_q || LATE_FIRE);
                late_inc   = rel_late_q && (|head_onehot);
                rel_late_d = nxt_same ? rel_late_q : nxt_late;
            end
            default:   ;
        endcase
        spike_d = fire ? head_onehot : '0;
    end

    // Datapath next values: FIFO pointers/level/storage, network time, late counter.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q[IDX_W-1:0]] = '{addr: ev_addr, ts: ev_time};
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      level_d = level_q + PTR_W'(1);
        else if (pop && !push) level_d = level_q - PTR_W'(1);
        sys_time_d = tick ? sys_time_q + TS_W'(1) : sys_time_q;
        late_cnt_d = (late_inc && late_cnt_q != 8'hFF) ? late_cnt_q + 8'd1 : late_cnt_q;
    end

    // Datapath registers; reset discards every buffered event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            sys_time_q <= '0;
            spike_q    <= '0;
            late_cnt_q <= '0;
            rel_late_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            sys_time_q <= sys_time_d;
            spike_q    <= spike_d;
            late_cnt_q <= late_cnt_d;
            rel_late_q <= rel_late_d;
        end
    end
endmodule
